// File: rtl/irq_ctrl.sv
// Eight-line priority interrupt controller: rising-edge request latch, per-line mask,
// fully nested in-service tracking with EOI, and an I/O register window at 0020h-0023h.
module irq_ctrl #(
    parameter int         HOLDOFF   = 16,
    parameter logic [7:0] VBASE_RST = 8'h08
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [15:0] port_a,
    input  logic        port_w,
    input  logic        port_r,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_i,
    output logic        port_hit,
    output logic        irq,
    output logic [7:0]  irq_in
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [7:0]  req_q_reg;
    logic [7:0]  irr_reg;
    logic [7:0]  isr_reg;
    logic [7:0]  imr_reg;
    logic [4:0]  vbase_reg;
    logic        irq_reg;
    logic [7:0]  irq_in_reg;

    logic [7:0]  req_edge;
    logic [7:0]  cand;
    logic [7:0]  blocked;
    logic [2:0]  sel_idx;
    logic        fire;
    logic [7:0]  fire_onehot;
    logic        wr_cmd;
    logic        wr_imr;
    logic        wr_vbase;
    logic [7:0]  isr_eoi;
    logic [7:0]  isr_next;
    logic [7:0]  irr_next;

    // Reads have no side effects, so the read strobe carries no information here.
    logic unused_port_r;
    assign unused_port_r = port_r;

    assign req_edge = req & ~req_q_reg;
    assign cand     = irr_reg & ~imr_reg;
    assign wr_cmd   = port_w && (port_a == 16'h0020);
    assign wr_imr   = port_w && (port_a == 16'h0021);
    assign wr_vbase = port_w && (port_a == 16'h0023);

    // A line is blocked when it or any higher-priority line is in service.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_blocked
            assign blocked[gi] = |isr_reg[gi:0];
        end
    endgenerate

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) sel_idx = 3'(i);
        end
    end

    assign fire        = (state_reg == IDLE) && (cand != 8'h00) && !blocked[sel_idx];
    assign fire_onehot = fire ? (8'b1 << sel_idx) : 8'b0;

    // EOI clears first, then a same-cycle fire re-sets; a new edge beats the fire-clear.
    always_comb begin
        isr_eoi = isr_reg;
        if (wr_cmd && port_o[6:5] == 2'b01) begin
            isr_eoi = isr_reg & (isr_reg - 8'd1);
        end else if (wr_cmd && port_o[6:5] == 2'b11) begin
            isr_eoi[port_o[2:0]] = 1'b0;
        end
        isr_next = isr_eoi | fire_onehot;
        irr_next = (irr_reg & ~fire_onehot) | req_edge;
    end

    always_comb begin
        port_hit = (port_a[15:2] == 14'h0008);
        case (port_a)
            16'h0020: port_i = irr_reg;
            16'h0021: port_i = imr_reg;
            16'h0022: port_i = isr_reg;
            16'h0023: port_i = {vbase_reg, 3'b000};
            default:  port_i = 8'hFF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 8'd0;
            req_q_reg  <= 8'h00;
            irr_reg    <= 8'h00;
            isr_reg    <= 8'h00;
            imr_reg    <= 8'hFF;
            vbase_reg  <= VBASE_RST[7:3];
            irq_reg    <= 1'b0;
            irq_in_reg <= VBASE_RST;
        end else begin
            req_q_reg <= req;
            irr_reg   <= irr_next;
            isr_reg   <= isr_next;
            if (wr_imr)   imr_reg   <= port_o;
            if (wr_vbase) vbase_reg <= port_o[7:3];
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        irq_reg    <= 1'b1;
                        irq_in_reg <= {vbase_reg, sel_idx};
                        cnt_reg    <= 8'(HOLDOFF - 1);
                        state_reg  <= HOLD;
                    end
                end
                HOLD: begin
                    irq_reg <= 1'b0;
                    if (cnt_reg == 8'd0) state_reg <= IDLE;
                    else                 cnt_reg   <= cnt_reg - 8'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign irq    = irq_reg;
    assign irq_in = irq_in_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: table of register-window reads after reset, then
// hand-written sequences for latency, priority, nesting, masking and reset corners.
module tb_irq_ctrl;

    localparam int HOLDOFF = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  req;
    logic [15:0] port_a;
    logic        port_w;
    logic        port_r;
    logic [7:0]  port_o;
    logic [7:0]  port_i;
    logic        port_hit;
    logic        irq;
    logic [7:0]  irq_in;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.HOLDOFF(HOLDOFF), .VBASE_RST(8'h08)) dut (
        .clock(clock), .reset(reset), .req(req),
        .port_a(port_a), .port_w(port_w), .port_r(port_r), .port_o(port_o),
        .port_i(port_i), .port_hit(port_hit), .irq(irq), .irq_in(irq_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        hit;
    } rd_vec_t;

    rd_vec_t rd_tab [9];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
        else $display("ok   %s: %02h", name, act);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        port_a = addr;
        port_o = data;
        port_w = 1'b1;
        step();
        port_w = 1'b0;
        port_a = 16'h0000;
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic [7:0] exp);
        port_a = addr;
        port_r = 1'b1;
        #1;
        check8(name, port_i, exp);
        port_r = 1'b0;
        port_a = 16'h0000;
    endtask

    task automatic run_count(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (irq === 1'b1) cnt++;
        end
    endtask

    task automatic wait_irq(input int budget, output int cyc);
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            cyc++;
            if (irq === 1'b1) return;
        end
        cyc = -1;
    endtask

    int cnt;
    int cyc;

    initial begin
        reset  = 1'b1;
        req    = 8'h00;
        port_a = 16'h0000;
        port_w = 1'b0;
        port_r = 1'b0;
        port_o = 8'h00;

        rd_tab[0] = '{16'h0020, 8'h00, 1'b1};
        rd_tab[1] = '{16'h0021, 8'hFF, 1'b1};
        rd_tab[2] = '{16'h0022, 8'h00, 1'b1};
        rd_tab[3] = '{16'h0023, 8'h08, 1'b1};
        rd_tab[4] = '{16'h0024, 8'hFF, 1'b0};
        rd_tab[5] = '{16'h0025, 8'hFF, 1'b0};
        rd_tab[6] = '{16'h001F, 8'hFF, 1'b0};
        rd_tab[7] = '{16'h1020, 8'hFF, 1'b0};
        rd_tab[8] = '{16'h0120, 8'hFF, 1'b0};

        #1;
        check8("rst_irq", {7'b0, irq}, 8'h00);
        check8("rst_irq_in", irq_in, 8'h08);
        for (int i = 0; i < 9; i++) begin
            port_a = rd_tab[i].addr;
            #1;
            check8($sformatf("tab%0d_data", i), port_i, rd_tab[i].data);
            check8($sformatf("tab%0d_hit", i), {7'b0, port_hit}, {7'b0, rd_tab[i].hit});
        end
        port_a = 16'h0000;
        step();
        step();
        reset = 1'b0;
        step();

        // Line 0: latency, single pulse while held high, ISR write ignored.
        wr(16'h0022, 8'hFF);
        rd("isr_wr_ignored", 16'h0022, 8'h00);
        wr(16'h0021, 8'hFE);
        req = 8'h01;
        step();
        check8("t1_no_irq_yet", {7'b0, irq}, 8'h00);
        rd("t1_irr_set", 16'h0020, 8'h01);
        step();
        check8("t1_irq", {7'b0, irq}, 8'h01);
        check8("t1_vec", irq_in, 8'h08);
        step();
        check8("t1_irq_drop", {7'b0, irq}, 8'h00);
        req = 8'h00;
        rd("t1_isr", 16'h0022, 8'h01);
        rd("t1_irr", 16'h0020, 8'h00);
        run_count(30, cnt);
        check8("t1_no_retrigger", 8'(cnt), 8'h00);
        wr(16'h0020, 8'h20);
        rd("t1_eoi", 16'h0022, 8'h00);

        // Priority between lines 1 and 3, and pulse spacing.
        wr(16'h0021, 8'h00);
        req = 8'h0A;
        step();
        step();
        check8("t2_irq1", {7'b0, irq}, 8'h01);
        check8("t2_vec1", irq_in, 8'h09);
        wr(16'h0020, 8'h20);
        req = 8'h00;
        wait_irq(40, cyc);
        check8("t2_spacing", 8'(cyc + 1), 8'(HOLDOFF + 1));
        check8("t2_vec2", irq_in, 8'h0B);
        rd("t2_isr", 16'h0022, 8'h08);
        wr(16'h0020, 8'h20);
        rd("t2_eoi", 16'h0022, 8'h00);
        run_count(20, cnt);
        check8("t2_quiet", 8'(cnt), 8'h00);

        // Nesting: line 4 blocked by line 1 in service, line 0 preempts.
        req = 8'h02;
        step();
        step();
        check8("t3_vec1", irq_in, 8'h09);
        req = 8'h00;
        run_count(20, cnt);
        req = 8'h10;
        step();
        run_count(25, cnt);
        check8("t3_blocked", 8'(cnt), 8'h00);
        rd("t3_irr", 16'h0020, 8'h10);
        req = 8'h11;
        step();
        step();
        check8("t3_nest_irq", {7'b0, irq}, 8'h01);
        check8("t3_nest_vec", irq_in, 8'h08);
        rd("t3_isr_nest", 16'h0022, 8'h03);
        req = 8'h00;
        run_count(20, cnt);
        wr(16'h0020, 8'h20);
        rd("t3_isr_after1", 16'h0022, 8'h02);
        wr(16'h0020, 8'h20);
        check8("t3_eoi_pre_isr", {7'b0, irq}, 8'h00);
        rd("t3_isr_after2", 16'h0022, 8'h00);
        step();
        check8("t3_freed_irq", {7'b0, irq}, 8'h01);
        check8("t3_freed_vec", irq_in, 8'h0C);
        rd("t3_isr4", 16'h0022, 8'h10);
        run_count(20, cnt);
        wr(16'h0020, 8'h20);

        // Vector base relocation.
        wr(16'h0023, 8'h70);
        req = 8'h80;
        step();
        step();
        check8("t4_vec", irq_in, 8'h77);
        req = 8'h00;
        rd("t4_vbase", 16'h0023, 8'h70);
        rd("t4_unmapped", 16'h0025, 8'hFF);
        port_a = 16'h0025;
        #1;
        check8("t4_nohit", {7'b0, port_hit}, 8'h00);
        port_a = 16'h0000;
        run_count(20, cnt);
        wr(16'h0020, 8'h20);
        wr(16'h0023, 8'h08);
        rd("t4_isr", 16'h0022, 8'h00);

        // Masked pending line, old-IMR evaluation, edge beating fire-clear, EOI forms.
        wr(16'h0021, 8'h04);
        req = 8'h04;
        step();
        req = 8'h00;
        run_count(25, cnt);
        check8("t5_masked", 8'(cnt), 8'h00);
        rd("t5_irr", 16'h0020, 8'h04);
        wr(16'h0021, 8'h00);
        check8("t5_old_imr", {7'b0, irq}, 8'h00);
        req = 8'h04;
        step();
        check8("t5_irq", {7'b0, irq}, 8'h01);
        check8("t5_vec", irq_in, 8'h0A);
        rd("t5_irr_setwins", 16'h0020, 8'h04);
        rd("t5_isr", 16'h0022, 8'h04);
        req = 8'h00;
        run_count(20, cnt);
        check8("t5_self_blocked", 8'(cnt), 8'h00);
        wr(16'h0020, 8'h40);
        rd("t5_ignored_cmd", 16'h0022, 8'h04);
        wr(16'h0020, 8'h62);
        check8("t5_spec_eoi_noirq", {7'b0, irq}, 8'h00);
        rd("t5_spec_eoi", 16'h0022, 8'h00);
        step();
        check8("t5_refire", {7'b0, irq}, 8'h01);
        check8("t5_refire_vec", irq_in, 8'h0A);
        run_count(20, cnt);
        wr(16'h0020, 8'h62);
        rd("t5_isr_clr", 16'h0022, 8'h00);
        rd("t5_irr_clr", 16'h0020, 8'h00);
        wr(16'h0020, 8'h20);
        rd("t5_ns_eoi_empty", 16'h0022, 8'h00);

        // Reset during the pulse with line 4 pending.
        req = 8'h12;
        step();
        step();
        check8("t6_irq", {7'b0, irq}, 8'h01);
        check8("t6_vec", irq_in, 8'h09);
        rd("t6_irr", 16'h0020, 8'h10);
        reset = 1'b1;
        #1;
        check8("t6_rst_irq", {7'b0, irq}, 8'h00);
        check8("t6_rst_vec", irq_in, 8'h08);
        rd("t6_rst_irr", 16'h0020, 8'h00);
        rd("t6_rst_isr", 16'h0022, 8'h00);
        rd("t6_rst_imr", 16'h0021, 8'hFF);
        req = 8'h00;
        step();
        step();
        reset = 1'b0;
        run_count(20, cnt);
        check8("t6_quiet_masked", 8'(cnt), 8'h00);
        wr(16'h0021, 8'h00);
        run_count(10, cnt);
        check8("t6_quiet_noedge", 8'(cnt), 8'h00);
        req = 8'h10;
        step();
        step();
        check8("t6_new_irq", {7'b0, irq}, 8'h01);
        check8("t6_new_vec", irq_in, 8'h0C);
        req = 8'h00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
